// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter in front of a shared bit-serial adder: one request is granted,
// its operands are added LSB-first over N cycles, and the sum is returned with a tagged done strobe.
module serial_add_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*N-1:0]        data0_i,
  input  logic [NREQ*N-1:0]        data1_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(NREQ)-1:0]  done_id_o,
  output logic [N:0]               sum_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, b_q;
  logic            c_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   ptr_q, idx_q, done_id_q;
  logic [N:0]      sum_q;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            sum_bit, carry_next, last_bit;

  // First pending request at or after the pointer, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_valid && req_i[(int'(ptr_q) + i) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign sum_bit    = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign last_bit   = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = RUN;
      RUN:     if (last_bit)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The result is registered on the last serial step so it is already valid during DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      done_id_q <= '0;
      sum_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            a_q   <= data0_i[int'(pick_idx)*N +: N];
            b_q   <= data1_i[int'(pick_idx)*N +: N];
            c_q   <= 1'b0;
            cnt_q <= '0;
            idx_q <= pick_idx;
          end
        end
        RUN: begin
          a_q   <= {sum_bit, a_q[N-1:1]};
          b_q   <= {1'b0, b_q[N-1:1]};
          c_q   <= carry_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            sum_q     <= {carry_next, sum_bit, a_q[N-1:1]};
            done_id_q <= idx_q;
          end
        end
        DONE: begin
          if (idx_q == IW'(NREQ - 1)) ptr_q <= '0;
          else                        ptr_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_o = '0;
    if (state_q == RUN && cnt_q == '0) gnt_o[idx_q] = 1'b1;
    busy_o    = (state_q != IDLE);
    done_o    = (state_q == DONE);
    done_id_o = done_id_q;
    sum_o     = sum_q;
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed and randomized check of serial_add_arbiter: grant order, latency, sums and reset abort.
module tb_serial_add_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req = '0;
  logic [31:0]     data0 = '0;
  logic [31:0]     data1 = '0;
  logic [3:0]      gnt;
  logic            busy, done;
  logic [1:0]      done_id;
  logic [8:0]      sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] d0;
    logic [31:0] d1;
    int          exp_id;
    logic [8:0]  exp_sum;
  } vec_t;

  vec_t vecs[11];

  serial_add_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data0_i(data0), .data1_i(data1),
    .gnt_o(gnt), .busy_o(busy), .done_o(done), .done_id_o(done_id), .sum_o(sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    req   = r;
    data0 = d0;
    data1 = d1;
  endtask

  // Expects a grant next cycle, then scrambles the operands, then a done N cycles later.
  task automatic checkOutput(input string name, input int exp_id, input logic [8:0] exp_sum);
    int waited;
    @(negedge clk);
    compare({name, " gnt"}, 32'(gnt), 32'(1) << exp_id);
    compare({name, " busy@gnt"}, 32'(busy), 32'd1);
    compare({name, " done@gnt"}, 32'(done), 32'd0);
    req   = '0;
    data0 = ~data0;
    data1 = data1 ^ 32'h5A5A_5A5A;
    waited = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (done || waited >= N + 4) break;
    end
    compare({name, " latency"}, 32'(waited), 32'(N));
    compare({name, " sum"}, 32'(sum), 32'(exp_sum));
    compare({name, " id"}, 32'(done_id), 32'(exp_id));
    compare({name, " busy@done"}, 32'(busy), 32'd1);
    compare({name, " gnt@done"}, 32'(gnt), 32'd0);
    @(negedge clk);
    compare({name, " idle busy"}, 32'(busy), 32'd0);
    compare({name, " idle done"}, 32'(done), 32'd0);
  endtask

  task automatic checkIdle(input string name);
    @(negedge clk);
    compare({name, " no gnt"}, 32'(gnt), 32'd0);
    compare({name, " not busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] da, db;
    logic [8:0]  held_sum[4];
    int          waited, prev_cyc, m_ptr, id;
    logic [3:0]  r;
    logic [31:0] d0, d1;
    logic [8:0]  es;
    bit          seen_done;

    da = 32'hFF33_80A5;
    db = 32'hFF44_805A;
    vecs[0]  = '{4'b0001, 32'h0000_00FF, 32'h0000_0001, 0, 9'h100};
    vecs[1]  = '{4'b1111, da, db, 1, 9'h100};
    vecs[2]  = '{4'b1111, da, db, 2, 9'h077};
    vecs[3]  = '{4'b1111, da, db, 3, 9'h1FE};
    vecs[4]  = '{4'b1111, da, db, 0, 9'h0FF};
    vecs[5]  = '{4'b0100, da, db, 2, 9'h077};
    vecs[6]  = '{4'b0101, da, db, 0, 9'h0FF};
    vecs[7]  = '{4'b0101, da, db, 2, 9'h077};
    vecs[8]  = '{4'b1000, 32'h0100_0000, 32'h0200_0000, 3, 9'h003};
    vecs[9]  = '{4'b0010, 32'h0000_0100, 32'h0000_FF00, 1, 9'h100};
    vecs[10] = '{4'b0011, 32'h0000_1234, 32'h0000_5678, 0, 9'h0AC};
    held_sum = '{9'h0FF, 9'h100, 9'h077, 9'h1FE};

    applyReset();
    compare("reset gnt", 32'(gnt), 32'd0);
    compare("reset busy", 32'(busy), 32'd0);
    compare("reset done", 32'(done), 32'd0);
    compare("reset id", 32'(done_id), 32'd0);
    compare("reset sum", 32'(sum), 32'd0);
    checkIdle("noreq");

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].req, vecs[i].d0, vecs[i].d1);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_sum);
    end

    // Held 1111 after reset: grants 0,1,2,3,0 spaced N+2 cycles apart.
    applyReset();
    applyStimulus(4'b1111, da, db);
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      while (1) begin
        @(negedge clk);
        waited++;
        if (gnt != 0 || waited >= 15) break;
      end
      compare($sformatf("held%0d gnt", k), 32'(gnt), 32'(1) << (k % 4));
      if (k > 0) compare($sformatf("held%0d spacing", k), 32'(cyc - prev_cyc), 32'(N + 2));
      prev_cyc = cyc;
      waited = 0;
      while (1) begin
        @(negedge clk);
        waited++;
        if (done || waited >= N + 4) break;
      end
      compare($sformatf("held%0d latency", k), 32'(waited), 32'(N));
      compare($sformatf("held%0d id", k), 32'(done_id), 32'(k % 4));
      compare($sformatf("held%0d sum", k), 32'(sum), 32'(held_sum[k % 4]));
      if (k == 4) req = '0;
    end

    // Reset during RUN cycle 4 aborts the operation and clears the pointer.
    applyStimulus(4'b0100, da, db);
    @(negedge clk);
    compare("abort gnt", 32'(gnt), 32'b0100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    compare("abort gnt0", 32'(gnt), 32'd0);
    compare("abort busy0", 32'(busy), 32'd0);
    compare("abort done0", 32'(done), 32'd0);
    compare("abort id0", 32'(done_id), 32'd0);
    compare("abort sum0", 32'(sum), 32'd0);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    compare("abort no done", 32'(seen_done), 32'd0);
    applyStimulus(4'b1001, da, db);
    checkOutput("postreset", 0, 9'h0FF);

    // Random operations against a behavioral round-robin/adder model.
    applyReset();
    m_ptr = 0;
    for (int op = 0; op < 1000; op++) begin
      r  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) r = '0;
      d0 = $urandom;
      d1 = $urandom;
      applyStimulus(r, d0, d1);
      if (r == 0) begin
        checkIdle($sformatf("rnd%0d", op));
      end else begin
        id = -1;
        for (int i = 0; i < NREQ; i++)
          if (id < 0 && r[(m_ptr + i) % NREQ]) id = (m_ptr + i) % NREQ;
        es = {1'b0, d0[id*8 +: 8]} + {1'b0, d1[id*8 +: 8]};
        checkOutput($sformatf("rnd%0d", op), id, es);
        m_ptr = (id + 1) % NREQ;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
